// File: rtl/pwm_ramp.sv
// pwm_ramp: breathing-LED duty ramp generator.
// Sweeps a LEN-bit level 0 -> MAX, holds HOLD ticks, sweeps back to 0, holds
// HOLD ticks and repeats. One tick every PRESC clocks; step size is a live input.
// Optional feature macro: PWM_RAMP_GAMMA_EN (square-law output curve).
module pwm_ramp #(
   parameter int LEN   = 8,
   parameter int PRESC = 1000,
   parameter int HOLD  = 64
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_en,
   input  logic [LEN-1:0] i_step,
   output logic [LEN-1:0] o_val,
   output logic           o_dir,
   output logic           o_busy,
   output logic           o_done
);

   localparam int PW = $clog2(PRESC);
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [LEN-1:0] MAX   = '1;
   localparam logic [PW-1:0]  PLAST = PW'(PRESC - 1);
   localparam logic [HW-1:0]  HLAST = HW'(HOLD - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RISE    = 3'd1;
   localparam logic [2:0] S_HOLD_HI = 3'd2;
   localparam logic [2:0] S_FALL    = 3'd3;
   localparam logic [2:0] S_HOLD_LO = 3'd4;

   logic [2:0]     r_state;
   logic [LEN-1:0] r_level;
   logic [PW-1:0]  r_pcnt;
   logic [HW-1:0]  r_hcnt;
   logic [LEN-1:0] r_val;
   logic           r_done;

   logic           w_tick;
   logic [LEN-1:0] w_step;
   logic [LEN:0]   w_sum;
   logic [LEN-1:0] w_up;
   logic [LEN-1:0] w_dn;
   logic [2:0]     w_state_n;
   logic [LEN-1:0] w_level_n;
   logic [PW-1:0]  w_pcnt_n;
   logic [HW-1:0]  w_hcnt_n;
   logic           w_done_n;
   logic [LEN-1:0] w_val_n;

   // Tick strobe and saturating step arithmetic (step 0 behaves as 1).
   always_comb begin
      w_tick = (r_state != S_IDLE) && (r_pcnt == PLAST);
      w_step = (i_step == '0) ? LEN'(1) : i_step;
      w_sum  = {1'b0, r_level} + {1'b0, w_step};
      w_up   = w_sum[LEN] ? MAX : w_sum[LEN-1:0];
      w_dn   = (r_level > w_step) ? (r_level - w_step) : '0;
   end

   // Next-state logic; a low enable wins over any coincident tick.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_state_n = r_state;
      w_level_n = r_level;
      w_pcnt_n  = w_tick ? '0 : r_pcnt + PW'(1);
      w_hcnt_n  = r_hcnt;
      w_done_n  = 1'b0;
      if (!i_en) begin
         w_state_n = S_IDLE;
         w_level_n = '0;
         w_pcnt_n  = '0;
         w_hcnt_n  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_n = S_RISE;
               w_level_n = '0;
               w_pcnt_n  = '0;
            end
            S_RISE: begin
               if (w_tick) begin
                  w_level_n = w_up;
                  if (w_up == MAX) begin
                     w_state_n = S_HOLD_HI;
                     w_hcnt_n  = '0;
                  end
               end
            end
            S_HOLD_HI: begin
               if (w_tick) begin
                  if (r_hcnt == HLAST) w_state_n = S_FALL;
                  else                 w_hcnt_n  = r_hcnt + HW'(1);
               end
            end
            S_FALL: begin
               if (w_tick) begin
                  w_level_n = w_dn;
                  if (w_dn == '0) begin
                     w_state_n = S_HOLD_LO;
                     w_hcnt_n  = '0;
                  end
               end
            end
            S_HOLD_LO: begin
               if (w_tick) begin
                  if (r_hcnt == HLAST) begin
                     w_state_n = S_RISE;
                     w_done_n  = 1'b1;
                  end else begin
                     w_hcnt_n = r_hcnt + HW'(1);
                  end
               end
            end
            default: begin
               w_state_n = S_IDLE;
               w_level_n = '0;
               w_pcnt_n  = '0;
               w_hcnt_n  = '0;
            end
         endcase
      end
   end

`ifdef PWM_RAMP_GAMMA_EN
   logic [2*LEN-1:0] w_sq;

   // Square-law curve (l*l + l) >> LEN keeps 0 -> 0 and MAX -> MAX exactly.
   always_comb begin
      w_sq    = (2*LEN)'(w_level_n) * (2*LEN)'(w_level_n) + (2*LEN)'(w_level_n);
      w_val_n = LEN'(w_sq >> LEN);
   end
`else
   // Linear output: the duty word is the level itself.
   always_comb begin
      w_val_n = w_level_n;
   end
`endif

   // State registers; val is derived from the next level so it has no extra latency.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (i_rst) begin
         r_state <= S_IDLE;
         r_level <= '0;
         r_pcnt  <= '0;
         r_hcnt  <= '0;
         r_val   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_level <= w_level_n;
         r_pcnt  <= w_pcnt_n;
         r_hcnt  <= w_hcnt_n;
         r_val   <= w_val_n;
         r_done  <= w_done_n;
      end
   end

   assign o_val  = r_val;
   assign o_done = r_done;
   assign o_busy = (r_state != S_IDLE);
   assign o_dir  = (r_state == S_RISE) || (r_state == S_HOLD_HI);

endmodule

// File: tb/tb_pwm_ramp.sv
// tb_pwm_ramp: scoreboard bench for pwm_ramp with LEN=3, PRESC=4, HOLD=2.
// Expected per-tick values are queued as stimulus is set up and popped on each tick.
module tb_pwm_ramp;

   localparam int LEN   = 3;
   localparam int PRESC = 4;
   localparam int HOLD  = 2;
   localparam int MAXV  = (1 << LEN) - 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [LEN-1:0] step;
   logic [LEN-1:0] val;
   logic           dir;
   logic           busy;
   logic           done;

   typedef struct packed {
      logic [LEN-1:0] val;
      logic           dir;
      logic           done;
   } exp_t;

   exp_t           sb_q[$];
   int             total = 0;
   int             bad   = 0;
   logic [LEN-1:0] last_val;
   logic           last_dir;

   pwm_ramp #(.LEN(LEN), .PRESC(PRESC), .HOLD(HOLD)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_en   (en),
      .i_step (step),
      .o_val  (val),
      .o_dir  (dir),
      .o_busy (busy),
      .o_done (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
      $fatal(1);
   end

   // Level -> output word as the downstream pwm should see it.
   function automatic logic [LEN-1:0] map_val(input int lvl);
`ifdef PWM_RAMP_GAMMA_EN
      case (lvl)
         0, 1, 2: return 3'd0;
         3:       return 3'd1;
         4:       return 3'd2;
         5:       return 3'd3;
         6:       return 3'd5;
         default: return 3'd7;
      endcase
`else
      return LEN'(lvl);
`endif
   endfunction

   task automatic push_tick(input int lvl, input logic d, input logic dn);
      exp_t e;
      e.val  = map_val(lvl);
      e.dir  = d;
      e.done = dn;
      sb_q.push_back(e);
   endtask

   // Expected ticks of one full period from RISE entry.
   task automatic push_period(input int stp);
      int s;
      int lvl;
      s   = (stp == 0) ? 1 : stp;
      lvl = 0;
      while (lvl < MAXV) begin
         lvl = (lvl + s > MAXV) ? MAXV : lvl + s;
         push_tick(lvl, 1'b1, 1'b0);
      end
      for (int h = 0; h < HOLD; h++) push_tick(MAXV, (h != HOLD - 1), 1'b0);
      while (lvl > 0) begin
         lvl = (lvl - s < 0) ? 0 : lvl - s;
         push_tick(lvl, 1'b0, 1'b0);
      end
      for (int h = 0; h < HOLD; h++) push_tick(0, (h == HOLD - 1), (h == HOLD - 1));
   endtask

   // Consume the queue: between ticks outputs must hold; on each tick compare.
   task automatic drain(input string name);
      exp_t e;
      while (sb_q.size() > 0) begin
         for (int c = 0; c < PRESC; c++) begin
            @(posedge clk); #1;
            if (c < PRESC - 1) begin
               total++;
               if (val !== last_val || done !== 1'b0 || busy !== 1'b1 || dir !== last_dir) begin
                  bad++;
                  $display("FAIL %s_hold: val=%0d done=%b busy=%b dir=%b want val=%0d done=0 busy=1 dir=%b",
                           name, val, done, busy, dir, last_val, last_dir);
               end
            end else begin
               e = sb_q.pop_front();
               total++;
               if (val !== e.val) begin
                  bad++;
                  $display("FAIL %s_val: got %0d want %0d", name, val, e.val);
               end
               total++;
               if (dir !== e.dir) begin
                  bad++;
                  $display("FAIL %s_dir: got %b want %b", name, dir, e.dir);
               end
               total++;
               if (done !== e.done) begin
                  bad++;
                  $display("FAIL %s_done: got %b want %b", name, done, e.done);
               end
               total++;
               if (busy !== 1'b1) begin
                  bad++;
                  $display("FAIL %s_busy: got %b want 1", name, busy);
               end
               last_val = e.val;
               last_dir = e.dir;
            end
         end
      end
   endtask

   task automatic start_run(input logic [LEN-1:0] stp, input string name);
      step = stp;
      en   = 1'b1;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b1 || dir !== 1'b1 || val !== '0 || done !== 1'b0) begin
         bad++;
         $display("FAIL %s_start: busy=%b dir=%b val=%0d done=%b want 1 1 0 0", name, busy, dir, val, done);
      end
      last_val = '0;
      last_dir = 1'b1;
   endtask

   task automatic stop_run(input string name);
      en = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || dir !== 1'b0 || val !== '0 || done !== 1'b0) begin
         bad++;
         $display("FAIL %s_stop: busy=%b dir=%b val=%0d done=%b want 0 0 0 0", name, busy, dir, val, done);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      en   = 1'b1;
      step = 3'd1;
      repeat (3) begin
         @(posedge clk); #1;
         total++;
         if (busy !== 1'b0 || val !== '0) begin
            bad++;
            $display("FAIL reset_over_en: busy=%b val=%0d want 0 0", busy, val);
         end
      end
      en  = 1'b0;
      rst = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         total++;
         if (val !== '0 || busy !== 1'b0 || done !== 1'b0 || dir !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: val=%0d busy=%b done=%b dir=%b want all 0", val, busy, done, dir);
         end
      end
   endtask

   task automatic test_linear();
      start_run(3'd1, "linear");
      push_period(1);
      drain("linear");
      stop_run("linear");
   endtask

   task automatic test_saturation();
      logic [LEN-1:0] vals [10];
      logic           dirs [10];
      vals = '{3'd3, 3'd6, 3'd7, 3'd7, 3'd7, 3'd4, 3'd1, 3'd0, 3'd0, 3'd0};
      dirs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      start_run(3'd3, "sat");
      for (int i = 0; i < 10; i++) push_tick(int'(vals[i]), dirs[i], (i == 9));
      drain("sat");
      stop_run("sat");
   endtask

   task automatic test_abort();
      start_run(3'd1, "abort");
      for (int l = 1; l <= 5; l++) push_tick(l, 1'b1, 1'b0);
      drain("abort");
      repeat (PRESC - 1) begin
         @(posedge clk); #1;
         total++;
         if (val !== map_val(5)) begin
            bad++;
            $display("FAIL abort_pre: got %0d want %0d", val, map_val(5));
         end
      end
      // The next edge is a tick; dropping en now must win over it.
      stop_run("abort");
      start_run(3'd1, "restart");
      push_tick(1, 1'b1, 1'b0);
      drain("restart");
      stop_run("restart");
   endtask

   task automatic test_step0();
      start_run(3'd0, "step0");
      push_period(1);
      drain("step0");
      stop_run("step0");
   endtask

   task automatic test_step_change();
      start_run(3'd1, "stepchg");
      push_tick(1, 1'b1, 1'b0);
      push_tick(2, 1'b1, 1'b0);
      drain("stepchg");
      step = 3'd3;
      push_tick(5, 1'b1, 1'b0);
      push_tick(7, 1'b1, 1'b0);
      drain("stepchg");
      stop_run("stepchg");
   endtask

   task automatic test_back_to_back();
      start_run(3'd2, "b2b");
      push_period(2);
      push_period(2);
      drain("b2b");
      stop_run("b2b");
   endtask

   initial begin
      test_reset();
      test_linear();
      test_saturation();
      test_abort();
      test_step0();
      test_step_change();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
